// File: rtl/ddr_wr_burst_packer_pkg.sv
// Shared types and default-configuration constants for the DDR write burst packer.
package ddr_pack_pkg;

  localparam int NUM_CH_DEF    = 2;
  localparam int IN_W_DEF      = 32;
  localparam int OUT_W_DEF     = 256;
  localparam int DEPTH_DEF     = 16;
  localparam int BURST_LEN_DEF = 4;

  localparam int RATIO = OUT_W_DEF / IN_W_DEF;
  localparam int CNT_W = $clog2(RATIO);
  localparam int PTR_W = $clog2(DEPTH_DEF);
  localparam int LVL_W = $clog2(DEPTH_DEF + 1);
  localparam int CH_W  = (NUM_CH_DEF > 1) ? $clog2(NUM_CH_DEF) : 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER
  } state_e;

  // Channel-select width; a single channel still needs one bit.
  function automatic int ch_w_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ddr_wr_burst_packer_if.sv
// Capture-side and DDR-controller-side signal bundle of the burst packer.
interface ddr_wr_burst_packer_if
  import ddr_pack_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int IN_W   = IN_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int SW = ch_w_of(NUM_CH);

  logic [NUM_CH-1:0]      in_valid;
  logic [NUM_CH*IN_W-1:0] in_data;
  logic [NUM_CH-1:0]      in_ready;
  logic [NUM_CH-1:0]      ch_flush;
  logic [NUM_CH*LW-1:0]   ch_level;
  logic                   burst_req;
  logic [SW-1:0]          burst_ch;
  logic                   burst_ack;
  logic                   out_valid;
  logic [OUT_W-1:0]       out_data;
  logic                   out_ready;
  logic                   out_last;

  modport master (
    output in_valid, in_data, ch_flush, burst_ack, out_ready,
    input  in_ready, ch_level, burst_req, burst_ch, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, ch_flush, burst_ack, out_ready,
    output in_ready, ch_level, burst_req, burst_ch, out_valid, out_data, out_last
  );

endinterface

// File: rtl/ddr_wr_burst_packer_chan.sv
// One capture channel: narrow-to-wide packer with flush, plus a wide-word buffer.
// PACK_MSB_FIRST_EN selects MSB-first slot order (padding then lands in the low bits).
module ddr_pack_chan
  import ddr_pack_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid_i,
  input  logic [IN_W-1:0]              in_data_i,
  input  logic                         flush_i,
  input  logic                         pop_i,
  output logic                         in_ready_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o,
  output logic [OUT_W-1:0]             head_o
);
  localparam int RAT = OUT_W / IN_W;
  localparam int CW  = $clog2(RAT);
  localparam int PW  = $clog2(DEPTH);
  localparam int LW  = $clog2(DEPTH + 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [OUT_W-1:0] word_q, word_d, fill_w;
  logic             pend_q, pend_d;
  logic [PW:0]      wr_q, rd_q;
  logic [LW-1:0]    lvl_q;
  logic [OUT_W-1:0] mem_q [DEPTH];

  logic full_w, last_slot_w, accept_w, has_part_w, flush_req_w, push_w;

  assign full_w      = (lvl_q == LW'(DEPTH));
  assign last_slot_w = (cnt_q == CW'(RAT - 1));
  // A pop in the same cycle is deliberately not credited here.
  assign in_ready_o  = !(full_w && (last_slot_w || pend_q));
  assign accept_w    = in_valid_i && in_ready_o;
  assign has_part_w  = (cnt_q != '0) || accept_w;
  assign flush_req_w = flush_i || pend_q;
  assign push_w      = (accept_w && last_slot_w) || (flush_req_w && has_part_w && !full_w);

  always_comb begin
    fill_w = word_q;
    if (accept_w) begin
`ifdef PACK_MSB_FIRST_EN
      fill_w[(RAT - 1 - int'(cnt_q))*IN_W +: IN_W] = in_data_i;
`else
      fill_w[int'(cnt_q)*IN_W +: IN_W] = in_data_i;
`endif
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    word_d = fill_w;
    pend_d = flush_req_w && has_part_w && full_w && !(accept_w && last_slot_w);
    if (push_w) begin
      cnt_d  = '0;
      word_d = '0;
    end else if (accept_w) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      word_q <= '0;
      pend_q <= 1'b0;
      wr_q   <= '0;
      rd_q   <= '0;
      lvl_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
      pend_q <= pend_d;
      if (push_w) wr_q <= wr_q + (PW+1)'(1);
      if (pop_i)  rd_q <= rd_q + (PW+1)'(1);
      case ({push_w, pop_i})
        2'b10:   lvl_q <= lvl_q + LW'(1);
        2'b01:   lvl_q <= lvl_q - LW'(1);
        default: lvl_q <= lvl_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_w) mem_q[wr_q[PW-1:0]] <= fill_w;
  end

  assign head_o  = mem_q[rd_q[PW-1:0]];
  assign level_o = lvl_q;

endmodule

// File: rtl/ddr_wr_burst_packer.sv
// Multi-channel DDR write burst packer: per-channel packers, round-robin burst arbiter, output mux.
// PACK_MSB_FIRST_EN (see ddr_pack_chan) selects MSB-first packing.
module ddr_wr_burst_packer
  import ddr_pack_pkg::*;
#(
  parameter int NUM_CH    = NUM_CH_DEF,
  parameter int IN_W      = IN_W_DEF,
  parameter int OUT_W     = OUT_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input logic                  clk,
  input logic                  rst,
  ddr_wr_burst_packer_if.slave bus
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int SW = ch_w_of(NUM_CH);
  localparam int BW = $clog2(BURST_LEN + 1);

  logic [LW-1:0]        level_w [NUM_CH];
  logic [OUT_W-1:0]     head_w  [NUM_CH];
  logic [NUM_CH-1:0]    pop_w, ready_w, elig_w;
  logic [NUM_CH*LW-1:0] level_flat_w;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    ddr_pack_chan #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .DEPTH (DEPTH)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .in_valid_i (bus.in_valid[g]),
      .in_data_i  (bus.in_data[g*IN_W +: IN_W]),
      .flush_i    (bus.ch_flush[g]),
      .pop_i      (pop_w[g]),
      .in_ready_o (ready_w[g]),
      .level_o    (level_w[g]),
      .head_o     (head_w[g])
    );
    assign level_flat_w[g*LW +: LW] = level_w[g];
    assign elig_w[g] = (level_w[g] >= LW'(BURST_LEN));
  end

  assign bus.in_ready = ready_w;
  assign bus.ch_level = level_flat_w;

  state_e        state_q, state_d;
  logic [SW-1:0] ch_q, ch_d, rr_q, rr_d, pick_ch;
  logic [BW-1:0] beat_q, beat_d;
  logic          pick_found, req_w, valid_w, last_w;
  int            pick_idx;

  // First eligible channel at or after the round-robin pointer.
  always_comb begin
    pick_found = 1'b0;
    pick_ch    = '0;
    pick_idx   = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      pick_idx = int'(rr_q) + i;
      if (pick_idx >= NUM_CH) pick_idx = pick_idx - NUM_CH;
      if (!pick_found && elig_w[pick_idx]) begin
        pick_found = 1'b1;
        pick_ch    = SW'(pick_idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    rr_d    = rr_q;
    beat_d  = beat_q;
    req_w   = 1'b0;
    valid_w = 1'b0;
    last_w  = 1'b0;
    pop_w   = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          ch_d    = pick_ch;
          beat_d  = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        req_w = 1'b1;
        if (bus.burst_ack) state_d = XFER;
      end
      XFER: begin
        valid_w = 1'b1;
        last_w  = (beat_q == BW'(BURST_LEN - 1));
        if (bus.out_ready) begin
          pop_w[ch_q] = 1'b1;
          if (last_w) begin
            beat_d  = '0;
            rr_d    = (ch_q == SW'(NUM_CH - 1)) ? '0 : ch_q + SW'(1);
            state_d = IDLE;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ch_q    <= '0;
      rr_q    <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
    end
  end

  assign bus.burst_req = req_w;
  assign bus.burst_ch  = ch_q;
  assign bus.out_valid = valid_w;
  assign bus.out_last  = last_w;
  assign bus.out_data  = valid_w ? head_w[ch_q] : '0;

endmodule

// File: doc/ddr_wr_burst_packer.md
Name: ddr_wr_burst_packer

Overview:
- Multi-channel, single-clock successor to the DDR write-side width-converting FIFO.
- Each of NUM_CH capture channels is packed from IN_W narrow words into OUT_W DDR words and buffered per channel.
- A round-robin arbiter emits fixed-length bursts of BURST_LEN wide words toward the DDR write controller.
- Adds two things the single-channel FIFO lacked: partial-word flush at end of line/frame, and a burst request/acknowledge handshake.

Parameters:
- NUM_CH, 2, number of input channels (1..8).
- IN_W, 32, input word width.
- OUT_W, 256, output word width; OUT_W/IN_W = RATIO, a power of two, at least 2.
- DEPTH, 16, per-channel buffer depth in OUT_W words; power of two.
- BURST_LEN, 4, OUT_W words per burst; must not exceed DEPTH.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset, asynchronous and active-high; clears all state.
- in_valid  in  NUM_CH  per-channel narrow-word valid.
- in_data  in  NUM_CH*IN_W  channel c occupies bits [c*IN_W +: IN_W].
- in_ready  out  NUM_CH  per-channel accept.
- ch_flush  in  NUM_CH  single-cycle pulse: zero-pad and push the partial word.
- ch_level  out  NUM_CH*clog2(DEPTH+1)  buffered wide words per channel.
- burst_req  out  1  a burst is pending.
- burst_ch  out  clog2(NUM_CH) (minimum 1)  channel of the pending or active burst.
- burst_ack  in  1  controller accepts the request.
- out_valid  out  1  wide data valid.
- out_data  out  OUT_W  wide data.
- out_ready  in  1  controller takes the word.
- out_last  out  1  final word of the burst.

Behaviour:
- Reset values: burst_req=0, burst_ch=0, out_valid=0, out_last=0, out_data=0, ch_level=0, in_ready=all 1, rr pointer=0, packer counts=0, flush-pending flags=0.
- Reset asserted mid-operation aborts any burst immediately; partial words and buffered data are discarded.
- Packer, per channel:
  - An accepted beat (in_valid&in_ready) fills slot cnt; cnt increments.
  - Slot order: slot 0 = bits [IN_W-1:0] (LSB-first).
  - When cnt reaches RATIO-1 and a beat is accepted, the full word is pushed to the channel buffer that cycle and cnt wraps to 0.
- in_ready[c] = !(buffer full && (cnt==RATIO-1 || flush pending)).
  - The check is conservative: a same-cycle pop is not credited.
- Flush:
  - ch_flush with cnt>0 pushes the word with unfilled slots zeroed and clears cnt.
  - A beat accepted in the same cycle is included before padding.
  - cnt==0 with no beat: no-op.
  - Buffer full: a sticky pending bit holds in_ready low until the push succeeds.
- Buffer:
  - Register array with wrap-around pointers of clog2(DEPTH) bits plus one extra bit for full/empty.
  - ch_level updates one cycle after a push or pop (registered).
  - Simultaneous push and pop leaves the level unchanged.
- FSM IDLE:
  - eligible[c] = ch_level[c] >= BURST_LEN.
  - If any channel is eligible, pick the first eligible channel at or after rr, latch burst_ch, go to REQ.
- FSM REQ:
  - burst_req=1 and burst_ch stay stable until burst_ack.
  - On burst_ack: burst_req=0, go to XFER next cycle.
- FSM XFER:
  - out_valid=1; out_data = head of the burst_ch buffer.
  - A pop occurs on out_valid&out_ready; a beat counter counts from 0 to BURST_LEN-1.
  - out_last=1 while the counter equals BURST_LEN-1.
  - When the last beat is taken: rr = burst_ch+1 mod NUM_CH; go to IDLE; out_valid=0 next cycle.
  - Holding out_ready low stalls with out_data stable.
- Eligibility guarantees no underflow during XFER. Pushes to the active channel continue throughout.
- Minimum gap: one IDLE cycle between bursts.

Optional Feature:
- Macro: PACK_MSB_FIRST_EN.
- When defined, slot 0 maps to bits [OUT_W-1 -: IN_W] and slots fill downward.
- Flush zero-padding then occupies the low bits.
- When undefined, slots are LSB-first as described under Behaviour.

Decomposition:
- Package ddr_pack_pkg holds:
  - FSM state enum {IDLE, REQ, XFER};
  - localparam helpers RATIO, CNT_W=clog2(RATIO), PTR_W=clog2(DEPTH), LVL_W=clog2(DEPTH+1), CH_W.
- Sub-module ddr_pack_chan, instantiated NUM_CH times by generate, contains the packer, flush logic and buffer.
- The top level holds the arbiter FSM and the output mux.

Test Plan:
All cases use defaults (NUM_CH=2, RATIO=8, DEPTH=16, BURST_LEN=4).
- Ch0 sends 32 beats 0x00..0x1F, ready always 1 -> burst_req with burst_ch=0; after ack, 4 words, word0=0x00000007_..._00000000, out_last on 4th; ch_level 4->0.
- Both channels hold ≥4 words, rr=0 -> bursts served in order ch0, ch1, ch0; burst_ch is never served twice while the other channel is eligible.
- Ch1 sends 3 beats 0xA,0xB,0xC then ch_flush -> one word pushed {160'h0, C, B, A}; cnt=0. Repeat with PACK_MSB_FIRST_EN -> {A, B, C, 160'h0}.
- Ch0 filled to 16 words plus 7 beats, no ack -> in_ready[0]=0. After a burst drains 4 words, in_ready[0]=1 and the 8th beat completes word 17.
- out_ready toggled 1,0,0,1 mid-burst -> out_data held stable while stalled; exactly 4 pops; out_last asserts only on the final beat.
- rst asserted during XFER beat 2 -> next cycle out_valid=0, burst_req=0, all ch_level=0, in_ready=all 1.
